// File: rtl/ball_pkg.sv
// rtl/ball_pkg.sv - shared widths, state type and helpers for ball motion
package ball_pkg;

    localparam int FRAC_BITS = 6;
    localparam int POS_W     = 17;
    localparam int VEL_W     = 10;
    localparam int BALL_SIZE = 32;

    typedef enum logic {
        IDLE,
        ROLLING
    } ball_state_t;

    // The most negative code has no positive mirror, so reflection could
    // overflow; clamp it one step in.
    function automatic logic signed [VEL_W-1:0] sat_vel(input logic signed [VEL_W-1:0] v);
        logic signed [VEL_W-1:0] r;
        r = v;
        if (v[VEL_W-1] && (v[VEL_W-2:0] == '0)) begin
            r = {1'b1, {(VEL_W-2){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/ball_axis.sv
// rtl/ball_axis.sv - one-axis combinational step: move, reflect, friction
module ball_axis
    import ball_pkg::*;
#(
    parameter int FRICTION_STEP = 1
) (
    input  logic        [POS_W-1:0] pos,
    input  logic signed [VEL_W-1:0] vel,
    input  logic        [POS_W-1:0] min_pos,
    input  logic        [POS_W-1:0] max_pos,
    input  logic                    fric_en,
    output logic        [POS_W-1:0] pos_next,
    output logic signed [VEL_W-1:0] vel_next
);

    localparam logic [VEL_W-1:0] STEP = VEL_W'(FRICTION_STEP);

    logic signed [POS_W:0]   sum;
    logic signed [VEL_W-1:0] vel_refl;
    logic        [VEL_W-1:0] vel_mag;

    always_comb begin
        // One extra signed bit so a step past zero reads as below min.
        sum      = $signed({1'b0, pos}) + $signed({{(POS_W + 1 - VEL_W){vel[VEL_W-1]}}, vel});
        pos_next = sum[POS_W-1:0];
        vel_refl = vel;
        if (sum < $signed({1'b0, min_pos})) begin
            pos_next = min_pos;
            vel_refl = -vel;
        end else if (sum > $signed({1'b0, max_pos})) begin
            pos_next = max_pos;
            vel_refl = -vel;
        end

        vel_mag  = vel_refl[VEL_W-1] ? $unsigned(-vel_refl) : $unsigned(vel_refl);
        vel_next = vel_refl;
        if (fric_en && (vel_refl != '0)) begin
            if (vel_mag <= STEP) begin
                vel_next = '0;
            end else if (vel_refl[VEL_W-1]) begin
                vel_next = vel_refl + $signed(STEP);
            end else begin
                vel_next = vel_refl - $signed(STEP);
            end
        end
    end

endmodule

// File: rtl/ball_move.sv
// rtl/ball_move.sv - per-ball position/velocity registers, roll FSM and friction timer
module ball_move
    import ball_pkg::*;
#(
    parameter int INIT_X          = 100,
    parameter int INIT_Y          = 200,
    parameter int TABLE_LEFT      = 40,
    parameter int TABLE_TOP       = 40,
    parameter int TABLE_RIGHT     = 600,
    parameter int TABLE_BOTTOM    = 440,
    parameter int BALL_SIZE       = ball_pkg::BALL_SIZE,
    parameter int FRICTION_PERIOD = 4,
    parameter int FRICTION_STEP   = 1
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    startOfFrame,
    input  logic                    hit,
    input  logic signed [VEL_W-1:0] hitVx,
    input  logic signed [VEL_W-1:0] hitVy,
    input  logic                    velLoad,
    input  logic signed [VEL_W-1:0] loadVx,
    input  logic signed [VEL_W-1:0] loadVy,
    output logic [10:0]             topLeftX,
    output logic [10:0]             topLeftY,
    output logic                    moving,
    output logic                    hitReady,
    output logic                    stopped
);

    localparam int CNT_W = (FRICTION_PERIOD > 1) ? $clog2(FRICTION_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRICTION_PERIOD - 1);

    localparam logic [POS_W-1:0] MIN_X  = POS_W'(TABLE_LEFT << FRAC_BITS);
    localparam logic [POS_W-1:0] MIN_Y  = POS_W'(TABLE_TOP << FRAC_BITS);
    localparam logic [POS_W-1:0] MAX_X  = POS_W'((TABLE_RIGHT - BALL_SIZE) << FRAC_BITS);
    localparam logic [POS_W-1:0] MAX_Y  = POS_W'((TABLE_BOTTOM - BALL_SIZE) << FRAC_BITS);
    localparam logic [POS_W-1:0] INIT_PX = POS_W'(INIT_X << FRAC_BITS);
    localparam logic [POS_W-1:0] INIT_PY = POS_W'(INIT_Y << FRAC_BITS);

    ball_state_t             state_q, state_d;
    logic        [POS_W-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic signed [VEL_W-1:0] vel_x_q, vel_x_d, vel_y_q, vel_y_d;
    logic        [CNT_W-1:0] fric_cnt_q, fric_cnt_d;
    logic                    stopped_q, stopped_d;

    logic                    fric_en;
    logic        [POS_W-1:0] step_pos_x, step_pos_y;
    logic signed [VEL_W-1:0] step_vel_x, step_vel_y;
    logic signed [VEL_W-1:0] load_vx_sat, load_vy_sat, hit_vx_sat, hit_vy_sat;

    assign fric_en     = (fric_cnt_q == CNT_LAST);
    assign load_vx_sat = sat_vel(loadVx);
    assign load_vy_sat = sat_vel(loadVy);
    assign hit_vx_sat  = sat_vel(hitVx);
    assign hit_vy_sat  = sat_vel(hitVy);

    ball_axis #(.FRICTION_STEP(FRICTION_STEP)) u_axis_x (
        .pos      (pos_x_q),
        .vel      (vel_x_q),
        .min_pos  (MIN_X),
        .max_pos  (MAX_X),
        .fric_en  (fric_en),
        .pos_next (step_pos_x),
        .vel_next (step_vel_x)
    );

    ball_axis #(.FRICTION_STEP(FRICTION_STEP)) u_axis_y (
        .pos      (pos_y_q),
        .vel      (vel_y_q),
        .min_pos  (MIN_Y),
        .max_pos  (MAX_Y),
        .fric_en  (fric_en),
        .pos_next (step_pos_y),
        .vel_next (step_vel_y)
    );

    always_comb begin
        state_d    = state_q;
        pos_x_d    = pos_x_q;
        pos_y_d    = pos_y_q;
        vel_x_d    = vel_x_q;
        vel_y_d    = vel_y_q;
        fric_cnt_d = fric_cnt_q;
        stopped_d  = 1'b0;

        if (velLoad) begin
            // Collision override: the frame's motion is dropped this cycle.
            vel_x_d = load_vx_sat;
            vel_y_d = load_vy_sat;
            if ((load_vx_sat != '0) || (load_vy_sat != '0)) begin
                state_d    = ROLLING;
                fric_cnt_d = '0;
            end else begin
                state_d   = IDLE;
                stopped_d = (state_q == ROLLING);
            end
        end else if (hit && (state_q == IDLE) && ((hit_vx_sat != '0) || (hit_vy_sat != '0))) begin
            vel_x_d    = hit_vx_sat;
            vel_y_d    = hit_vy_sat;
            fric_cnt_d = '0;
            state_d    = ROLLING;
        end else if ((state_q == ROLLING) && startOfFrame) begin
            pos_x_d    = step_pos_x;
            pos_y_d    = step_pos_y;
            vel_x_d    = step_vel_x;
            vel_y_d    = step_vel_y;
            fric_cnt_d = fric_en ? '0 : fric_cnt_q + 1'b1;
            if ((step_vel_x == '0) && (step_vel_y == '0)) begin
                state_d   = IDLE;
                stopped_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q    <= IDLE;
            pos_x_q    <= INIT_PX;
            pos_y_q    <= INIT_PY;
            vel_x_q    <= '0;
            vel_y_q    <= '0;
            fric_cnt_q <= '0;
            stopped_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            vel_x_q    <= vel_x_d;
            vel_y_q    <= vel_y_d;
            fric_cnt_q <= fric_cnt_d;
            stopped_q  <= stopped_d;
        end
    end

    assign topLeftX = pos_x_q[POS_W-1:FRAC_BITS];
    assign topLeftY = pos_y_q[POS_W-1:FRAC_BITS];
    assign moving   = (state_q == ROLLING);
    assign hitReady = (state_q == IDLE);
    assign stopped  = stopped_q;

endmodule
